// File: rtl/axi_lite_write_bcast_ctrl_if.sv
// AXI4-Lite write-channel bundle. NUM_PORTS handshake lanes share one AW address and one W
// payload; BRESP carries one 2-bit response per lane, lane i in [2i+1:2i].
interface axi_lite_write_bcast_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 1
);
  logic [NUM_PORTS-1:0]    AWVALID;
  logic [NUM_PORTS-1:0]    AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [NUM_PORTS-1:0]    WVALID;
  logic [NUM_PORTS-1:0]    WREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic [NUM_PORTS-1:0]    BVALID;
  logic [NUM_PORTS-1:0]    BREADY;
  logic [2*NUM_PORTS-1:0]  BRESP;

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/axi_lite_write_bcast_ctrl.sv
// Broadcasts one AXI4-Lite write from a single master to NUM_SLR slave ports, tracking AW, W
// and B completion per slave, merging the slave responses by severity and counting failed
// writes in a saturating counter.
module axi_lite_write_bcast_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_SLR       = 4,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_SLR-1:0]        slr_enable,
  axi_lite_write_bcast_ctrl_if.slave  s_axi,
  axi_lite_write_bcast_ctrl_if.master m_axi,
  output logic [ERR_CNT_WIDTH-1:0]  err_count
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StBcast, StResp} state_e;

  state_e                   r_state;
  logic                     r_aw_cap;
  logic                     r_w_cap;
  logic [NUM_SLR-1:0]       r_en;
  logic [NUM_SLR-1:0]       r_aw_done;
  logic [NUM_SLR-1:0]       r_w_done;
  logic [NUM_SLR-1:0]       r_b_done;
  logic [1:0]               r_merged_resp;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [StrbWidth-1:0]     r_strb;

  logic               w_s_awready;
  logic               w_s_wready;
  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_in_bcast;
  logic [NUM_SLR-1:0] w_en_next;
  logic [NUM_SLR-1:0] w_m_awvalid;
  logic [NUM_SLR-1:0] w_m_wvalid;
  logic [NUM_SLR-1:0] w_m_bready;
  logic [NUM_SLR-1:0] w_aw_acc;
  logic [NUM_SLR-1:0] w_w_acc;
  logic [NUM_SLR-1:0] w_b_acc;
  logic [1:0]         w_merged_next;

  // Severity merge: DECERR > SLVERR > OKAY; EXOKAY is folded into OKAY.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b11 || b == 2'b11) return 2'b11;
    if (a == 2'b10 || b == 2'b10) return 2'b10;
    return 2'b00;
  endfunction

  // Readies are gated by reset so the master never sees a handshake while reset is held.
  assign w_s_awready = ap_rst_n & (r_state == StIdle) & ~r_aw_cap;
  assign w_s_wready  = ap_rst_n & (r_state == StIdle) & ~r_w_cap;
  assign w_aw_hs     = s_axi.AWVALID[0] & w_s_awready;
  assign w_w_hs      = s_axi.WVALID[0] & w_s_wready;
  assign w_en_next   = w_aw_hs ? slr_enable : r_en;

  assign w_in_bcast  = (r_state == StBcast);
  assign w_m_awvalid = {NUM_SLR{w_in_bcast}} & ~r_aw_done;
  assign w_m_wvalid  = {NUM_SLR{w_in_bcast}} & ~r_w_done;
  // B is accepted per slave as soon as that slave has taken both AW and W.
  assign w_m_bready  = {NUM_SLR{w_in_bcast}} & r_aw_done & r_w_done & ~r_b_done;
  assign w_aw_acc    = w_m_awvalid & m_axi.AWREADY;
  assign w_w_acc     = w_m_wvalid & m_axi.WREADY;
  assign w_b_acc     = w_m_bready & m_axi.BVALID;

  // Fold every response accepted this cycle into the running merged response.
  always_comb begin
    w_merged_next = r_merged_resp;
    for (int i = 0; i < NUM_SLR; i++) begin
      if (w_b_acc[i]) w_merged_next = resp_merge(w_merged_next, m_axi.BRESP[2*i +: 2]);
    end
  end

  // Transaction FSM: capture AW/W, broadcast with per-slave tracking, return merged B.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= StIdle;
      r_aw_cap      <= 1'b0;
      r_w_cap       <= 1'b0;
      r_en          <= '0;
      r_aw_done     <= '0;
      r_w_done      <= '0;
      r_b_done      <= '0;
      r_merged_resp <= 2'b00;
      r_err_count   <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_strb        <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_aw_hs) begin
            r_aw_cap <= 1'b1;
            r_addr   <= s_axi.AWADDR;
            r_en     <= slr_enable;
          end
          if (w_w_hs) begin
            r_w_cap <= 1'b1;
            r_data  <= s_axi.WDATA;
            r_strb  <= s_axi.WSTRB;
          end
          if ((r_aw_cap | w_aw_hs) & (r_w_cap | w_w_hs)) begin
            r_state   <= StBcast;
            // Disabled slaves start out complete so they never see a valid or BREADY.
            r_aw_done <= ~w_en_next;
            r_w_done  <= ~w_en_next;
            r_b_done  <= ~w_en_next;
          end
        end
        StBcast: begin
          r_aw_done     <= r_aw_done | w_aw_acc;
          r_w_done      <= r_w_done | w_w_acc;
          r_b_done      <= r_b_done | w_b_acc;
          r_merged_resp <= w_merged_next;
          if (&r_b_done) r_state <= StResp;
        end
        StResp: begin
          if (s_axi.BREADY[0]) begin
            r_state       <= StIdle;
            r_aw_cap      <= 1'b0;
            r_w_cap       <= 1'b0;
            r_aw_done     <= '0;
            r_w_done      <= '0;
            r_b_done      <= '0;
            r_merged_resp <= 2'b00;
            if (r_merged_resp != 2'b00 && r_err_count != '1) begin
              r_err_count <= r_err_count + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s_axi.AWREADY = w_s_awready;
  assign s_axi.WREADY  = w_s_wready;
  assign s_axi.BVALID  = (r_state == StResp);
  assign s_axi.BRESP   = r_merged_resp;

  assign m_axi.AWVALID = w_m_awvalid;
  assign m_axi.AWADDR  = r_addr;
  assign m_axi.WVALID  = w_m_wvalid;
  assign m_axi.WDATA   = r_data;
  assign m_axi.WSTRB   = r_strb;
  assign m_axi.BREADY  = w_m_bready;

  assign err_count = r_err_count;

endmodule

// File: tb/tb_axi_lite_write_bcast_ctrl.sv
// Directed bench for axi_lite_write_bcast_ctrl: one master driver, four behavioural slaves
// with programmable AWREADY stall and BRESP, cycle-stamped handshakes checked against
// hand-computed latencies. The error counter is narrowed so saturation is reachable quickly.
module tb_axi_lite_write_bcast_ctrl;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned EW = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [NS-1:0] slr_enable;
  logic [EW-1:0] err_count;

  axi_lite_write_bcast_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(1)) s_if ();
  axi_lite_write_bcast_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NS)) m_if ();

  axi_lite_write_bcast_ctrl #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_SLR      (NS),
    .ERR_CNT_WIDTH(EW)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .slr_enable(slr_enable),
    .s_axi     (s_if),
    .m_axi     (m_if),
    .err_count (err_count)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_pass = 0;
  int cycle = 0;

  // Slave model state and statistics
  int            aw_hold [NS];
  int            aw_cnt  [NS];
  int            w_cnt   [NS];
  int            b_cnt   [NS];
  int            aw_cyc  [NS];
  int            b_cyc   [NS];
  logic          aw_got  [NS];
  logic          w_got   [NS];
  logic [1:0]    bresp_cfg [NS];
  logic [AW-1:0] last_addr [NS];
  logic [DW-1:0] last_data [NS];
  logic [3:0]    last_strb [NS];
  logic [NS-1:0] valid_seen;
  logic [NS-1:0] bready_seen;
  int            retract_viol = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NS; i++) begin
      aw_cnt[i] = 0; w_cnt[i] = 0; b_cnt[i] = 0; aw_cyc[i] = -1; b_cyc[i] = -1;
    end
    valid_seen = '0;
    bready_seen = '0;
  endtask

  // Behavioural slaves: sample handshakes at the falling edge, update after the rising edge.
  initial begin : slave_model
    logic [NS-1:0] aw_hs, w_hs, b_hs, awv_wait, wv_wait;
    awv_wait = '0;
    wv_wait = '0;
    for (int i = 0; i < NS; i++) begin
      aw_hold[i] = 0; aw_got[i] = 1'b0; w_got[i] = 1'b0; bresp_cfg[i] = 2'b00;
    end
    m_if.AWREADY = '1;
    m_if.WREADY  = '1;
    m_if.BVALID  = '0;
    m_if.BRESP   = '0;
    forever begin
      @(negedge ap_clk);
      aw_hs = m_if.AWVALID & m_if.AWREADY;
      w_hs  = m_if.WVALID & m_if.WREADY;
      b_hs  = m_if.BVALID & m_if.BREADY;
      retract_viol += $countones((awv_wait & ~m_if.AWVALID) | (wv_wait & ~m_if.WVALID));
      awv_wait = m_if.AWVALID & ~m_if.AWREADY;
      wv_wait  = m_if.WVALID & ~m_if.WREADY;
      valid_seen  = valid_seen | m_if.AWVALID | m_if.WVALID;
      bready_seen = bready_seen | m_if.BREADY;
      for (int i = 0; i < NS; i++) begin
        if (aw_hs[i]) begin aw_cnt[i]++; aw_cyc[i] = cycle; last_addr[i] = m_if.AWADDR; end
        if (w_hs[i]) begin
          w_cnt[i]++; last_data[i] = m_if.WDATA; last_strb[i] = m_if.WSTRB;
        end
        if (b_hs[i]) begin b_cnt[i]++; b_cyc[i] = cycle; end
      end
      @(posedge ap_clk);
      #1;
      cycle++;
      for (int i = 0; i < NS; i++) begin
        if (!ap_rst_n) begin
          aw_got[i] = 1'b0; w_got[i] = 1'b0; aw_hold[i] = 0;
        end else begin
          if (aw_hs[i]) aw_got[i] = 1'b1;
          if (w_hs[i]) w_got[i] = 1'b1;
          if (b_hs[i]) begin aw_got[i] = 1'b0; w_got[i] = 1'b0; end
          if (aw_hold[i] > 0) aw_hold[i]--;
        end
        m_if.AWREADY[i]      = (aw_hold[i] == 0);
        m_if.BVALID[i]       = aw_got[i] & w_got[i];
        m_if.BRESP[2*i +: 2] = bresp_cfg[i];
      end
      if (!ap_rst_n) begin awv_wait = '0; wv_wait = '0; end
    end
  end

  // Master AW/W; W leads AW by w_lead cycles. t0 is the cycle of the last master handshake.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                      input int w_lead, output int t0, output bit wrdy_after);
    bit aw_pend, w_pend, aw_ok, w_ok;
    int n;
    aw_pend = 1'b1; w_pend = 1'b1; t0 = -1; wrdy_after = 1'b0; n = 0;
    s_if.WVALID = 1'b1; s_if.WDATA = d; s_if.WSTRB = s; s_if.AWADDR = a;
    while ((aw_pend || w_pend) && n < 40) begin
      if (n >= w_lead && aw_pend) s_if.AWVALID = 1'b1;
      @(negedge ap_clk);
      aw_ok = s_if.AWVALID[0] & s_if.AWREADY[0];
      w_ok  = s_if.WVALID[0] & s_if.WREADY[0];
      if (!w_pend && s_if.WREADY[0]) wrdy_after = 1'b1;
      if (aw_ok || w_ok) t0 = cycle;
      tick();
      if (aw_ok) begin aw_pend = 1'b0; s_if.AWVALID = 1'b0; end
      if (w_ok) begin w_pend = 1'b0; s_if.WVALID = 1'b0; end
      n++;
    end
  endtask

  // Master B with BREADY held high; tb stays -1 if the bound expires.
  task automatic wait_b(output int tb, output logic [1:0] resp);
    int n;
    tb = -1; resp = 2'bxx; n = 0;
    s_if.BREADY = 1'b1;
    while (tb < 0 && n < 60) begin
      @(negedge ap_clk);
      if (s_if.BVALID[0]) begin tb = cycle; resp = s_if.BRESP; end
      tick();
      n++;
    end
    s_if.BREADY = 1'b0;
  endtask

  task automatic set_bresp(input logic [1:0] r0, input logic [1:0] r1,
                           input logic [1:0] r2, input logic [1:0] r3);
    bresp_cfg[0] = r0; bresp_cfg[1] = r1; bresp_cfg[2] = r2; bresp_cfg[3] = r3;
  endtask

  initial begin : main
    int t0, tb, bv_seen;
    bit wrdy_after;
    logic [1:0] resp;
    slr_enable = '1;
    s_if.AWVALID = 1'b0; s_if.AWADDR = '0; s_if.WVALID = 1'b0; s_if.WDATA = '0;
    s_if.WSTRB = '0; s_if.BREADY = 1'b0;
    clear_stats();

    // Reset state
    #3;
    check_val("rst_s_awready", s_if.AWREADY, 0);
    check_val("rst_s_wready", s_if.WREADY, 0);
    check_val("rst_s_bvalid", s_if.BVALID, 0);
    check_val("rst_m_valids", {m_if.AWVALID, m_if.WVALID, m_if.BREADY}, 0);
    check_val("rst_err_count", err_count, 0);
    check_val("rst_m_awaddr", m_if.AWADDR, 0);
    tick(); tick();
    ap_rst_n = 1'b1;
    tick();
    check_val("idle_s_awready", s_if.AWREADY, 1);

    // T1: same-cycle AW/W, all slaves ready, minimum latency
    clear_stats();
    send(9'h010, 32'hDEADBEEF, 4'hF, 0, t0, wrdy_after);
    wait_b(tb, resp);
    for (int i = 0; i < NS; i++) begin
      check_val("t1_aw_cnt", aw_cnt[i], 1);
      check_val("t1_w_cnt", w_cnt[i], 1);
      check_val("t1_aw_cyc", aw_cyc[i], t0 + 1);
    end
    check_val("t1_m_wstrb", last_strb[3], 4'hF);
    check_val("t1_b_latency", tb, t0 + 4);
    check_val("t1_bresp", resp, 2'b00);
    check_val("t1_err_count", err_count, 0);

    // T2: W three cycles ahead of AW
    clear_stats();
    send(9'h010, 32'hDEADBEEF, 4'hF, 3, t0, wrdy_after);
    wait_b(tb, resp);
    check_val("t2_wready_after_cap", wrdy_after, 0);
    for (int i = 0; i < NS; i++) begin
      check_val("t2_w_cnt", w_cnt[i], 1);
      check_val("t2_addr", last_addr[i], 9'h010);
      check_val("t2_data", last_data[i], 32'hDEADBEEF);
    end
    check_val("t2_b_latency", tb, t0 + 4);

    // T3: slave 2 AWREADY stalled; early B from others, master B after slave 2
    clear_stats();
    aw_hold[2] = 6;
    send(9'h044, 32'h12345678, 4'h3, 0, t0, wrdy_after);
    wait_b(tb, resp);
    for (int i = 0; i < NS; i++) check_val("t3_aw_cnt", aw_cnt[i], 1);
    check_val("t3_aw2_cyc", aw_cyc[2], t0 + 6);
    check_val("t3_b1_cyc", b_cyc[1], t0 + 2);
    check_val("t3_b2_cyc", b_cyc[2], t0 + 7);
    check_val("t3_b_latency", tb, t0 + 9);
    check_val("t3_no_retract", retract_viol, 0);

    // T5a: only slaves 0 and 2 enabled; disabled slave 1 error must not leak in
    clear_stats();
    set_bresp(2'b00, 2'b11, 2'b00, 2'b00);
    slr_enable = 4'b0101;
    send(9'h100, 32'hA5A5A5A5, 4'hF, 0, t0, wrdy_after);
    slr_enable = '1;
    wait_b(tb, resp);
    check_val("t5_valid_seen", valid_seen, 4'b0101);
    check_val("t5_bready_seen", bready_seen, 4'b0101);
    check_val("t5_bresp", resp, 2'b00);
    check_val("t5_b_latency", tb, t0 + 4);

    // T5b: all slaves disabled
    clear_stats();
    slr_enable = 4'b0000;
    send(9'h101, 32'h0, 4'h0, 0, t0, wrdy_after);
    slr_enable = '1;
    wait_b(tb, resp);
    check_val("t5z_valid_seen", {valid_seen, bready_seen}, 0);
    check_val("t5z_b_latency", tb, t0 + 2);
    check_val("t5z_bresp", resp, 2'b00);
    check_val("t5z_err_count", err_count, 0);

    // T4: response merge and error counter
    set_bresp(2'b00, 2'b10, 2'b01, 2'b11);
    send(9'h020, 32'h1, 4'h1, 0, t0, wrdy_after);
    wait_b(tb, resp);
    check_val("t4_decerr", resp, 2'b11);
    check_val("t4_err1", err_count, 1);
    set_bresp(2'b01, 2'b10, 2'b00, 2'b00);
    send(9'h020, 32'h2, 4'h1, 0, t0, wrdy_after);
    wait_b(tb, resp);
    check_val("t4_slverr", resp, 2'b10);
    check_val("t4_err2", err_count, 2);
    set_bresp(2'b01, 2'b01, 2'b01, 2'b01);
    send(9'h020, 32'h3, 4'h1, 0, t0, wrdy_after);
    wait_b(tb, resp);
    check_val("t4_exokay", resp, 2'b00);
    check_val("t4_err_hold", err_count, 2);
    set_bresp(2'b11, 2'b11, 2'b11, 2'b11);
    for (int k = 0; k < 13; k++) begin
      send(9'h030, k, 4'hF, 0, t0, wrdy_after);
      wait_b(tb, resp);
    end
    check_val("t4_err_max", err_count, 4'hF);
    send(9'h030, 32'hFF, 4'hF, 0, t0, wrdy_after);
    wait_b(tb, resp);
    check_val("t4_err_saturate", err_count, 4'hF);
    set_bresp(2'b00, 2'b00, 2'b00, 2'b00);

    // T6: reset during BCAST with slaves 2 and 3 still waiting on AW
    clear_stats();
    aw_hold[2] = 30;
    aw_hold[3] = 30;
    send(9'h0F0, 32'hCAFEF00D, 4'hF, 0, t0, wrdy_after);
    tick(); tick();
    @(negedge ap_clk);
    check_val("t6_pending_awvalid", m_if.AWVALID, 4'b1100);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_val("t6_rst_awvalid", m_if.AWVALID, 0);
    check_val("t6_rst_wvalid_bready", {m_if.WVALID, m_if.BREADY}, 0);
    check_val("t6_rst_err_count", err_count, 0);
    tick();
    ap_rst_n = 1'b1;
    bv_seen = 0;
    s_if.BREADY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      if (s_if.BVALID[0]) bv_seen++;
      tick();
    end
    s_if.BREADY = 1'b0;
    check_val("t6_no_bvalid", bv_seen, 0);
    clear_stats();
    send(9'h0F4, 32'h0BADC0DE, 4'hC, 0, t0, wrdy_after);
    wait_b(tb, resp);
    check_val("t6_after_b_latency", tb, t0 + 4);
    check_val("t6_after_bresp", resp, 2'b00);
    check_val("t6_after_aw3", aw_cnt[3], 1);
    check_val("t6_after_data3", last_data[3], 32'h0BADC0DE);
    check_val("t6_no_retract", retract_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
